// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: digit type, segment lookup and blank pattern shared by the display scanner
package bcd_disp_pkg;
    localparam int DIGITS = 4;
    typedef logic [3:0] bcd_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Active-high gfedcba patterns; non-BCD codes map to all-off so they invert to blank
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };
endpackage

// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: valid/ready digit handshake from the upstream BCD encoder
interface bcd_display_scanner_if;
    import bcd_disp_pkg::*;
    bcd_t bcd_in;
    logic bcd_valid;
    logic bcd_ready;
    modport master (output bcd_in, output bcd_valid, input bcd_ready);
    modport slave (input bcd_in, input bcd_valid, output bcd_ready);
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low 7-segment decoder, codes 10-15 blank
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);
    assign seg = ~SEG_LUT[digit];
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: 4-digit BCD shift store scanned onto a multiplexed 7-segment display.
// Optional BCD_BLANK_LEAD_ZERO_EN blanks leading zero positions above digit 0.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_display_scanner_if.slave  bus,
    input  logic                  clear,
    output logic [6:0]            seg,
    output logic [3:0]            an,
    output logic                  err
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    bcd_t d [DIGITS];
    logic [CW-1:0] cnt;
    logic [1:0] sel;
    logic accept, blank, wrap;
    bcd_t shown;
    logic [6:0] seg_next;
    assign bus.bcd_ready = !rst && !clear;
    assign accept = bus.bcd_valid && bus.bcd_ready;
    assign wrap = cnt == LAST;
`ifdef BCD_BLANK_LEAD_ZERO_EN
    logic [DIGITS-1:0] nz;
    always_comb begin
        nz = '0;
        for (int i = 0; i < DIGITS; i++) nz[i] = |d[i];
    end
    // A position is leading when it and every digit above it are zero
    assign blank = sel != 2'd0 && (nz >> sel) == '0;
`else
    assign blank = 1'b0;
`endif
    assign shown = blank ? 4'hF : d[sel];
    bcd_to_seg7 u_dec (.digit(shown), .seg(seg_next));
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) d[i] <= '0;
            cnt <= '0;
            sel <= '0;
            err <= 1'b0;
            an <= 4'hF;
            seg <= SEG_BLANK;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            sel <= wrap ? sel + 1'b1 : sel;
            an <= ~(4'b0001 << sel);
            seg <= seg_next;
            if (clear) begin
                for (int i = 0; i < DIGITS; i++) d[i] <= '0;
                err <= 1'b0;
            end else if (accept && bus.bcd_in > 4'd9) begin
                err <= 1'b1;
            end else if (accept) begin
                for (int i = DIGITS - 1; i > 0; i--) d[i] <= d[i-1];
                d[0] <= bus.bcd_in;
            end
        end
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed, table-driven and random checks against a decimal-number model
module tb_bcd_display_scanner;
    localparam int DIV = 4;
    localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam int P10 [4] = '{1, 10, 100, 1000};
`ifdef BCD_BLANK_LEAD_ZERO_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif
    typedef struct { logic [3:0] bcd; logic [6:0] exp; } vec_t;
    logic clk = 0, rst = 1, clear = 0;
    logic [6:0] seg;
    logic [3:0] an;
    logic err;
    int checks = 0, errors = 0;
    bcd_display_scanner_if bus();
    bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .bus(bus), .clear(clear), .seg(seg), .an(an), .err(err)
    );
    always #5 clk = ~clk;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction
    // Store modelled as a 4-digit decimal number; scan position derived from edges since reset
    int m_val, m_n, m_pos;
    bit m_err, m_ok = 0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    function automatic logic [6:0] disp(int pos);
`ifdef BCD_BLANK_LEAD_ZERO_EN
        if (pos != 0 && m_val < P10[pos]) return 7'h7F;
`endif
        return ~PAT[(m_val / P10[pos]) % 10];
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            m_val = 0; m_err = 0; m_n = 0; m_ok = 1;
            e_an = 4'hF; e_seg = 7'h7F;
        end else begin
            m_pos = (m_n / DIV) % 4;
            e_an = 4'hF;
            e_an[m_pos] = 1'b0;
            e_seg = disp(m_pos);
            m_n++;
            if (clear) begin
                m_val = 0; m_err = 0;
            end else if (bus.bcd_valid) begin
                if (bus.bcd_in > 9) m_err = 1;
                else m_val = (m_val * 10 + int'(bus.bcd_in)) % 10000;
            end
        end
    end
    always @(negedge clk) if (m_ok) begin
        chk("model_an", an, e_an);
        chk("model_seg", seg, e_seg);
        chk("model_err", err, m_err);
        chk("model_ready", bus.bcd_ready, !rst && !clear);
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic send(input logic [3:0] v);
        bus.bcd_in = v;
        bus.bcd_valid = 1;
        tick();
        bus.bcd_valid = 0;
    endtask
    task automatic check_scan(input string name, input logic [6:0] s0, s1, s2, s3);
        logic [6:0] exp [4];
        logic [3:0] prev, ea;
        bit found;
        exp = '{s0, s1, s2, s3};
        found = 0;
        @(negedge clk);
        prev = an;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            found = prev == 4'b0111 && an == 4'b1110;
            prev = an;
        end
        chk({name, "_sync"}, 32'(found), 1);
        if (found) for (int k = 0; k < 16; k++) begin
            if (k != 0) @(negedge clk);
            ea = 4'hF;
            ea[k/4] = 1'b0;
            chk({name, "_an"}, an, ea);
            chk({name, "_seg"}, seg, exp[k/4]);
        end
    endtask
    vec_t vecs [10];
    initial begin
        bit seen;
        vecs = '{'{4'd0, 7'h40}, '{4'd1, 7'h79}, '{4'd2, 7'h24}, '{4'd3, 7'h30}, '{4'd4, 7'h19},
                 '{4'd5, 7'h12}, '{4'd6, 7'h02}, '{4'd7, 7'h78}, '{4'd8, 7'h00}, '{4'd9, 7'h10}};
        bus.bcd_in = 0;
        bus.bcd_valid = 0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_ready", bus.bcd_ready, 0);
        #1 rst = 0;
        @(negedge clk);
        chk("rel_an", an, 4'hE);
        chk("rel_seg", seg, 7'h40);
        tick();
        send(1); send(2); send(3); send(4);
        check_scan("s1234", 7'h19, 7'h30, 7'h24, 7'h79);
        tick();
        send(5);
        check_scan("s2345", 7'h12, 7'h19, 7'h30, 7'h24);
        tick();
        send(12);
        @(negedge clk);
        chk("err_set", err, 1);
        check_scan("s_err_keep", 7'h12, 7'h19, 7'h30, 7'h24);
        chk("err_sticky", err, 1);
        tick();
        clear = 1;
        tick();
        clear = 0;
        @(negedge clk);
        chk("clr_err", err, 0);
        check_scan("s_clr", 7'h40, LZ, LZ, LZ);
        tick();
        clear = 1;
        bus.bcd_valid = 1;
        bus.bcd_in = 7;
        @(negedge clk);
        chk("clr_ready", bus.bcd_ready, 0);
        tick();
        clear = 0;
        bus.bcd_valid = 0;
        check_scan("s_clr_wins", 7'h40, LZ, LZ, LZ);
        tick();
        send(0); send(0); send(4); send(2);
        check_scan("s_0042", 7'h24, 7'h19, LZ, LZ);
        foreach (vecs[v]) begin
            tick();
            clear = 1;
            tick();
            clear = 0;
            send(vecs[v].bcd);
            tick();
            seen = 0;
            for (int i = 0; i < 32 && !seen; i++) begin
                @(negedge clk);
                seen = an == 4'b1110;
            end
            chk("vec_sync", 32'(seen), 1);
            chk("vec_seg", seg, vecs[v].exp);
        end
        for (int i = 0; i < 1500; i++) begin
            tick();
            rst = $urandom % 300 == 0;
            clear = $urandom % 60 == 0;
            bus.bcd_valid = 1'($urandom % 2);
            bus.bcd_in = $urandom % 8 == 0 ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9, 0));
        end
        tick();
        rst = 0;
        clear = 0;
        bus.bcd_valid = 0;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles each digit position is displayed; legal range 2..2^20.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 bcd_in  input  4  BCD digit from the upstream decimal-to-BCD encoder.
REQ-005 bcd_valid  input  1  bcd_in holds a new digit this cycle.
REQ-006 bcd_ready  output  1  block accepts a digit this cycle.
REQ-007 clear  input  1  synchronous clear of the stored digits and the error flag.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}; active-low.
REQ-009 an  output  4  digit enables; active-low one-hot; an[0] is the rightmost digit.
REQ-010 err  output  1  sticky flag: a non-BCD code (greater than 9) was offered.

Function
REQ-011 Digit store: four 4-bit registers d3..d0; d0 is the rightmost digit.
REQ-012 bcd_ready shall be 1 in every cycle except while rst=1 or clear=1.
REQ-013 Accept occurs when bcd_valid & bcd_ready; a legal digit (0-9) shifts the store left (d3<=d2, d2<=d1, d1<=d0, d0<=bcd_in); the old d3 is discarded.
REQ-014 An accepted code of 10-15 shall not shift the store; it shall set err to 1 on the next edge.
REQ-015 Once set, err shall stay 1 until rst or clear.
REQ-016 clear=1 shall set d3..d0 to 0 and err to 0; clear together with bcd_valid: clear wins and the digit is dropped.
REQ-017 Prescaler: a counter runs 0..REFRESH_DIV-1 and wraps to 0; the cycle it wraps, the position select sel (2 bits) shall advance 0,1,2,3,0.
REQ-018 seg and an shall be registered; they reflect sel and the digit store one cycle after the edge that changed sel or the store.
REQ-019 an shall equal ~(4'b0001 << sel); seg shall be the active-low 7-segment pattern of d[sel].
REQ-020 Segment encodings (active-high, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; seg outputs their bitwise inverses.
REQ-021 A store update while a digit is being displayed shall appear on seg one cycle later, without waiting for the next scan.

Reset
REQ-022 While rst=1: d3..d0=0, prescaler=0, sel=0, err=0, bcd_ready=0, an=4'b1111, seg=7'b1111111.
REQ-023 On the first edge after rst falls: an=4'b1110, seg=7'b1000000 (digit 0).
REQ-024 rst asserted mid-scan or mid-accept shall override all other activity on that edge.

Configuration
REQ-025 Macro BCD_BLANK_LEAD_ZERO_EN:
- Defined: any position above the highest nonzero digit shall drive seg=7'b1111111 while an still scans. Position 0 is never blanked, so all-zero shows a single "0".
- Undefined: every position always shows its digit, including leading zeros.

Structure
REQ-026 Package bcd_disp_pkg shall hold the segment constants, the blank pattern, and the digit-count localparam (4).
REQ-027 Combinational sub-module bcd_to_seg7: 4-bit digit in, 7-bit active-low seg out; codes 10-15 output blank.
REQ-028 The top level shall contain only the store, prescaler, select, and output registers; target size 120-400 RTL lines.

Verification (bench overrides REFRESH_DIV=4)
REQ-029 Apply rst for 2 cycles, then release -> an=1111 and seg=1111111 during rst; an=1110, seg=1000000 on the first edge after release.
REQ-030 Send digits 1,2,3,4 on consecutive cycles -> d3..d0=1,2,3,4. Over the following 16 cycles the bench shall see (an=1110, seg=~66), (1101, ~4F), (1011, ~5B), (0111, ~06), each for 4 cycles.
REQ-031 Send digit 5 after 1,2,3,4 -> the store becomes 2,3,4,5 and digit 1 is discarded.
REQ-032 Offer bcd_in=12 with bcd_valid=1 -> the store is unchanged and err=1 on the next edge. Then pulse clear -> err=0, digits all 0.
REQ-033 Assert clear and bcd_valid (bcd_in=7) in the same cycle -> the store is all 0 and 7 is not stored; bcd_ready=0 that cycle.
REQ-034 With BCD_BLANK_LEAD_ZERO_EN defined, store 0,0,4,2 -> positions 3 and 2 show 1111111, position 1 shows ~66, position 0 shows ~5B. With all-zero store -> only position 0 shows ~3F.
